fsk_frame_rx: RTL and testbench

//  Receive end of the FSK link: demodulates the tone-coded serial line driven by the FSK

---
 rtl/fsk_frame_rx.sv | 211 +++++++++++++++++++++
 tb/tb_fsk_frame_rx.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fsk_frame_rx.sv
// FSK frame receiver: counts line edges per bit window to recover 9-bit even-parity words
// and delivers the data byte on a valid/ready handshake.
// Optional build macro FSK_RX_STATS_EN adds saturating good_cnt / perr_cnt outputs.
module fsk_frame_rx #(
   parameter int unsigned F0_HALF     = 8,
   parameter int unsigned F1_HALF     = 4,
   parameter int unsigned BIT_CYCLES  = 64,
   parameter int unsigned EDGE_THRESH = 12,
   parameter int unsigned MIN_EDGES   = 4,
   parameter int unsigned IDLE_CYCLES = 128
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       fsk_in,
   output logic [7:0] data_out,
   output logic       valid,
   input  logic       ready,
   output logic       parity_err,
   output logic       frame_err,
   output logic       overrun
`ifdef FSK_RX_STATS_EN
   ,
   output logic [15:0] good_cnt,
   output logic [15:0] perr_cnt
`endif
);

   localparam int unsigned WinW   = $clog2(BIT_CYCLES);
   localparam int unsigned EdgeW  = $clog2(BIT_CYCLES + 1);
   localparam int unsigned QuietW = $clog2(IDLE_CYCLES + 1);

   localparam logic [WinW-1:0]   WinLast   = WinW'(BIT_CYCLES - 1);
   localparam logic [EdgeW-1:0]  EdgeMax   = '1;
   localparam logic [EdgeW-1:0]  EdgeOne   = EdgeW'(1);
   localparam logic [EdgeW-1:0]  OneThresh = EdgeW'(EDGE_THRESH);
   localparam logic [EdgeW-1:0]  MinEdges  = EdgeW'(MIN_EDGES);
   localparam logic [QuietW-1:0] QuietMax  = QuietW'(IDLE_CYCLES);

   // Nominal tone edge counts must straddle the decision threshold.
   if ((BIT_CYCLES / F0_HALF) >= EDGE_THRESH || (BIT_CYCLES / F0_HALF) < MIN_EDGES ||
       (BIT_CYCLES / F1_HALF) < EDGE_THRESH) begin : g_bad_tone_params
      $error("fsk_frame_rx: tone half-periods do not fit EDGE_THRESH/MIN_EDGES");
   end

   typedef enum logic [1:0] {StIdle, StRecv, StCheck} state_e;

   state_e            state_q, state_d;
   logic [1:0]        sync_q, sync_d;
   logic              line_prev_q, line_prev_d;
   logic [QuietW-1:0] quiet_q, quiet_d;
   logic [WinW-1:0]   win_q, win_d;
   logic [EdgeW-1:0]  edge_cnt_q, edge_cnt_d;
   logic [3:0]        bit_cnt_q, bit_cnt_d;
   logic [8:0]        word_q, word_d;
   logic [7:0]        data_q, data_d;
   logic              valid_q, valid_d;
   logic              perr_q, perr_d;
   logic              ferr_q, ferr_d;
   logic              ovr_q, ovr_d;
   logic              edge_det;
   logic              good_frame;

   assign edge_det = sync_q[1] ^ line_prev_q;

   // Next-state: synchronizer, idle qualification, per-window edge counting, word check.
   always_comb begin
      state_d     = state_q;
      sync_d      = {sync_q[0], fsk_in};
      line_prev_d = sync_q[1];
      quiet_d     = quiet_q;
      win_d       = win_q;
      edge_cnt_d  = edge_cnt_q;
      bit_cnt_d   = bit_cnt_q;
      word_d      = word_q;
      data_d      = data_q;
      valid_d     = valid_q;
      perr_d      = 1'b0;
      ferr_d      = 1'b0;
      ovr_d       = ovr_q;
      good_frame  = 1'b0;

      if (valid_q && ready) begin
         valid_d = 1'b0;
      end

      unique case (state_q)
         StIdle: begin
            if (edge_det) begin
               quiet_d = '0;
               if (quiet_q == QuietMax) begin
                  state_d    = StRecv;
                  bit_cnt_d  = '0;
                  win_d      = '0;
                  edge_cnt_d = EdgeOne;
               end
            end else if (quiet_q != QuietMax) begin
               quiet_d = quiet_q + QuietW'(1);
            end
         end
         StRecv: begin
            win_d = win_q + WinW'(1);
            if (edge_det && edge_cnt_q != EdgeMax) begin
               edge_cnt_d = edge_cnt_q + EdgeOne;
            end
            if (win_q == WinLast) begin
               word_d = {word_q[7:0], (edge_cnt_q >= OneThresh)};
               if (edge_cnt_q < MinEdges) begin
                  ferr_d  = 1'b1;
                  state_d = StIdle;
                  quiet_d = '0;
               end else begin
                  // A boundary-cycle edge belongs to the next window.
                  win_d      = '0;
                  edge_cnt_d = edge_det ? EdgeOne : '0;
                  bit_cnt_d  = bit_cnt_q + 4'd1;
                  if (bit_cnt_q == 4'd8) begin
                     state_d = StCheck;
                  end
               end
            end
         end
         StCheck: begin
            state_d = StIdle;
            quiet_d = '0;
            if (^word_q) begin
               perr_d = 1'b1;
            end else begin
               good_frame = 1'b1;
               if (!valid_q || ready) begin
                  data_d  = word_q[8:1];
                  valid_d = 1'b1;
               end else begin
                  ovr_d = 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         sync_q      <= '0;
         line_prev_q <= 1'b0;
         quiet_q     <= '0;
         win_q       <= '0;
         edge_cnt_q  <= '0;
         bit_cnt_q   <= '0;
         word_q      <= '0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         perr_q      <= 1'b0;
         ferr_q      <= 1'b0;
         ovr_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         sync_q      <= sync_d;
         line_prev_q <= line_prev_d;
         quiet_q     <= quiet_d;
         win_q       <= win_d;
         edge_cnt_q  <= edge_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         word_q      <= word_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         perr_q      <= perr_d;
         ferr_q      <= ferr_d;
         ovr_q       <= ovr_d;
      end
   end

   assign data_out   = data_q;
   assign valid      = valid_q;
   assign parity_err = perr_q;
   assign frame_err  = ferr_q;
   assign overrun    = ovr_q;

`ifdef FSK_RX_STATS_EN
   logic [15:0] good_cnt_q, good_cnt_d;
   logic [15:0] perr_cnt_q, perr_cnt_d;

   // Saturating frame statistics; overrun drops still count as good frames.
   always_comb begin
      good_cnt_d = good_cnt_q;
      perr_cnt_d = perr_cnt_q;
      if (good_frame && good_cnt_q != 16'hFFFF) begin
         good_cnt_d = good_cnt_q + 16'd1;
      end
      if (perr_d && perr_cnt_q != 16'hFFFF) begin
         perr_cnt_d = perr_cnt_q + 16'd1;
      end
   end

   // Statistics registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         good_cnt_q <= '0;
         perr_cnt_q <= '0;
      end else begin
         good_cnt_q <= good_cnt_d;
         perr_cnt_q <= perr_cnt_d;
      end
   end

   assign good_cnt = good_cnt_q;
   assign perr_cnt = perr_cnt_q;
`endif

endmodule

// File: tb/tb_fsk_frame_rx.sv
// Directed bench for fsk_frame_rx: drives nominal FSK tones and checks bytes, error pulses,
// latencies and the handshake against hand-computed values.
module tb_fsk_frame_rx;

   logic       clk;
   logic       reset;
   logic       fsk_in;
   logic [7:0] data_out;
   logic       valid;
   logic       ready;
   logic       parity_err;
   logic       frame_err;
   logic       overrun;
`ifdef FSK_RX_STATS_EN
   logic [15:0] good_cnt;
   logic [15:0] perr_cnt;
`endif

   fsk_frame_rx dut (
      .clk        (clk),
      .reset      (reset),
      .fsk_in     (fsk_in),
      .data_out   (data_out),
      .valid      (valid),
      .ready      (ready),
      .parity_err (parity_err),
      .frame_err  (frame_err),
      .overrun    (overrun)
`ifdef FSK_RX_STATS_EN
      ,
      .good_cnt   (good_cnt),
      .perr_cnt   (perr_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   // Free-running cycle counter and pulse monitors sampled on the falling edge.
   int   cyc       = 0;
   int   vrise_n   = 0;
   int   vrise_cyc = 0;
   int   perr_n    = 0;
   int   perr_cyc  = 0;
   int   ferr_n    = 0;
   int   ferr_cyc  = 0;
   logic valid_prev = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      valid_prev <= valid;
      if (valid && !valid_prev) begin
         vrise_n   <= vrise_n + 1;
         vrise_cyc <= cyc;
      end
      if (parity_err) begin
         perr_n   <= perr_n + 1;
         perr_cyc <= cyc;
      end
      if (frame_err) begin
         ferr_n   <= ferr_n + 1;
         ferr_cyc <= cyc;
      end
   end

   int start_cyc, vrise_base, perr_base, ferr_base;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Transmit one 9-bit word MSB-first; stop_bit cuts the carrier in that window,
   // rst_bit pulses reset inside that window and checks the cleared outputs.
   task automatic send_word(input logic [8:0] w, input int stop_bit, input int rst_bit);
      int half;
      start_cyc  = cyc;
      vrise_base = vrise_n;
      perr_base  = perr_n;
      ferr_base  = ferr_n;
      for (int i = 0; i < 9; i++) begin
         half = w[8-i] ? 4 : 8;
         for (int c = 0; c < 64; c++) begin
            if (i == rst_bit && c == 10) begin
               reset = 1'b1;
               @(posedge clk);
               #1;
               reset = 1'b0;
               check("rst_valid", {31'd0, valid}, 32'd0);
               check("rst_data", {24'd0, data_out}, 32'd0);
               check("rst_overrun", {31'd0, overrun}, 32'd0);
               check("rst_perr", {31'd0, parity_err}, 32'd0);
               check("rst_ferr", {31'd0, frame_err}, 32'd0);
`ifdef FSK_RX_STATS_EN
               check("rst_good_cnt", {16'd0, good_cnt}, 32'd0);
               check("rst_perr_cnt", {16'd0, perr_cnt}, 32'd0);
`endif
            end
            if ((stop_bit < 0 || i < stop_bit || (i == stop_bit && c < 16)) &&
                (c % half == 0)) begin
               fsk_in = ~fsk_in;
            end
            @(posedge clk);
            #1;
         end
      end
   endtask

   // Let the CHECK result land and the negedge monitors record it.
   task automatic finish_frame();
      repeat (5) @(posedge clk);
      #1;
   endtask

   task automatic quiet(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_ready();
      ready = 1'b1;
      @(posedge clk);
      #1;
      ready = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset  = 1'b1;
      fsk_in = 1'b0;
      ready  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_valid", {31'd0, valid}, 32'd0);
      check("reset_data", {24'd0, data_out}, 32'd0);
      check("reset_flags", {29'd0, parity_err, frame_err, overrun}, 32'd0);
      reset = 1'b0;
      quiet(200);

      // Good A5 frame (even parity bit 0): valid 580 cycles after the start toggle.
      send_word(9'h14A, -1, -1);
      finish_frame();
      check("t1_valid", {31'd0, valid}, 32'd1);
      check("t1_data", {24'd0, data_out}, 32'hA5);
      check("t1_valid_lat", vrise_cyc - start_cyc, 32'd580);
      check("t1_no_err", (perr_n - perr_base) + (ferr_n - ferr_base), 32'd0);
      pulse_ready();
      check("t1_consumed", {31'd0, valid}, 32'd0);

      // A5 with parity bit 1 has odd parity and is dropped.
      quiet(200);
      send_word(9'h14B, -1, -1);
      finish_frame();
      check("t1b_perr_n", perr_n - perr_base, 32'd1);
      check("t1b_perr_lat", perr_cyc - start_cyc, 32'd580);
      check("t1b_valid", {31'd0, valid}, 32'd0);

      // Odd-parity word 0_0000_0001.
      quiet(200);
      send_word(9'h001, -1, -1);
      finish_frame();
      check("t2_perr_n", perr_n - perr_base, 32'd1);
      check("t2_perr_lat", perr_cyc - start_cyc, 32'd580);
      check("t2_valid", {31'd0, valid}, 32'd0);
      check("t2_data", {24'd0, data_out}, 32'hA5);
`ifdef FSK_RX_STATS_EN
      check("t2_perr_cnt", {16'd0, perr_cnt}, 32'd2);
`endif

      // Carrier lost in window 4: frame_err at that window boundary (cycle 323).
      quiet(200);
      send_word(9'h14A, 4, -1);
      check("t3_ferr_n", ferr_n - ferr_base, 32'd1);
      check("t3_ferr_lat", ferr_cyc - start_cyc, 32'd323);
      check("t3_no_valid", vrise_n - vrise_base, 32'd0);
      check("t3_no_perr", perr_n - perr_base, 32'd0);
      send_word(9'h0F0, -1, -1);
      finish_frame();
      check("t3_recover_valid", {31'd0, valid}, 32'd1);
      check("t3_recover_data", {24'd0, data_out}, 32'h78);
      pulse_ready();

      // Overrun: 3C held while 7E arrives with ready low.
      quiet(200);
      send_word(9'h078, -1, -1);
      finish_frame();
      check("t4_first_data", {24'd0, data_out}, 32'h3C);
      check("t4_ovr_before", {31'd0, overrun}, 32'd0);
      quiet(200);
      send_word(9'h0FC, -1, -1);
      finish_frame();
      check("t4_data_held", {24'd0, data_out}, 32'h3C);
      check("t4_valid_held", {31'd0, valid}, 32'd1);
      check("t4_overrun", {31'd0, overrun}, 32'd1);
      pulse_ready();
      check("t4_consumed", {31'd0, valid}, 32'd0);
      check("t4_overrun_sticky", {31'd0, overrun}, 32'd1);

      // Start edge too soon after a frame is ignored; a later frame is received.
      quiet(200);
      send_word(9'h0B4, -1, -1);
      finish_frame();
      check("t5_first_data", {24'd0, data_out}, 32'h5A);
      pulse_ready();
      quiet(92);
      send_word(9'h14A, -1, -1);
      finish_frame();
      check("t5_ignored_valid", vrise_n - vrise_base, 32'd0);
      check("t5_ignored_err", (perr_n - perr_base) + (ferr_n - ferr_base), 32'd0);
      quiet(200);
      send_word(9'h14A, -1, -1);
      finish_frame();
      check("t5_late_valid", {31'd0, valid}, 32'd1);
      check("t5_late_data", {24'd0, data_out}, 32'hA5);
`ifdef FSK_RX_STATS_EN
      check("t5_good_cnt", {16'd0, good_cnt}, 32'd6);
      check("t5_perr_cnt", {16'd0, perr_cnt}, 32'd2);
`endif

      // Reset during bit 5 (valid and overrun are set going in).
      quiet(200);
      send_word(9'h0F0, -1, 5);
      finish_frame();
      check("t6_no_valid", vrise_n - vrise_base, 32'd0);
      check("t6_valid", {31'd0, valid}, 32'd0);
      check("t6_no_ferr", ferr_n - ferr_base, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
